// File: rtl/pad_reader.sv
// Serial pad reader: pulses latch, then clocks BITS bits MSB-first from a
// shift-register responder and presents the assembled word with a valid pulse.
module pad_reader #(
  parameter int unsigned BITS         = 16,
  parameter int unsigned HALF_CYCLES  = 8,
  parameter int unsigned LATCH_CYCLES = 12
) (
  input  logic            system_clock,
  input  logic            reset_n,
  input  logic            start,
  output logic            latch,
  output logic            clk,
  input  logic            data,
  output logic [BITS-1:0] o,
  output logic            valid,
  output logic            busy
);

  localparam int unsigned CW = 16;
  localparam int unsigned BW = $clog2(BITS + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LATCH = 3'd1;
  localparam logic [2:0] S_LOW   = 3'd2;
  localparam logic [2:0] S_HIGH  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [CW-1:0] HALF_LAST  = CW'(HALF_CYCLES - 1);
  localparam logic [CW-1:0] LATCH_LAST = CW'(LATCH_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST   = BW'(BITS);

  logic [2:0]      state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [BITS-1:0] shift_q, shift_d;
  logic [1:0]      sync_q;
  logic            data_s;

  // Two-flop synchronizer; idles at the pad's pulled-up level
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= {sync_q[0], data};
  end

  assign data_s = sync_q[1];

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  // Next-state: cnt_q counts cycles spent in the current timed state
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (start) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = S_LOW;
          cnt_d   = '0;
          bit_d   = '0;
        end
      end
      S_LOW: begin
        if (cnt_q == HALF_LAST) begin
          shift_d = BITS'({shift_q, data_s});
          bit_d   = bit_q + BW'(1);
          state_d = S_HIGH;
          cnt_d   = '0;
        end
      end
      S_HIGH: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          state_d = (bit_q == BIT_LAST) ? S_DONE : S_LOW;
        end
      end
      S_DONE: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Registered outputs decoded from the current state
  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      latch <= 1'b0;
      clk   <= 1'b1;
      busy  <= 1'b0;
      valid <= 1'b0;
      o     <= '1;
    end else begin
      latch <= (state_q == S_LATCH);
      clk   <= (state_q != S_LOW);
      busy  <= (state_q != S_IDLE);
      valid <= (state_q == S_DONE);
      if (state_q == S_DONE) o <= shift_q;
    end
  end

endmodule

// File: tb/tb_pad_reader.sv
// Directed bench for pad_reader: shift-register responder models drive data
// back to two instances (default parameters and a short 8-bit variant).
module tb_pad_reader;

  logic        system_clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        latch, pad_clk, data, valid, busy;
  logic [15:0] o;
  logic        start2 = 1'b0;
  logic        latch2, pad_clk2, data2, valid2, busy2;
  logic [7:0]  o2;

  logic [15:0] word1 = 16'h0000;
  logic [15:0] rsp1;
  logic        pclk_q1;
  logic [7:0]  word2 = 8'h00;
  logic [7:0]  rsp2;
  logic        pclk_q2;

  int total = 0;
  int bad = 0;

  always #5 system_clock = ~system_clock;

  pad_reader dut (
    .system_clock(system_clock), .reset_n(reset_n), .start(start),
    .latch(latch), .clk(pad_clk), .data(data), .o(o), .valid(valid), .busy(busy)
  );

  pad_reader #(.BITS(8), .HALF_CYCLES(8), .LATCH_CYCLES(1)) dut2 (
    .system_clock(system_clock), .reset_n(reset_n), .start(start2),
    .latch(latch2), .clk(pad_clk2), .data(data2), .o(o2), .valid(valid2), .busy(busy2)
  );

  // Responder: parallel load while latch is high, shift on each clk rising edge
  always @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp1 <= '1; pclk_q1 <= 1'b1;
    end else begin
      pclk_q1 <= pad_clk;
      if (latch) rsp1 <= word1;
      else if (pad_clk && !pclk_q1) rsp1 <= {rsp1[14:0], 1'b1};
    end
  end
  assign data = rsp1[15];

  always @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      rsp2 <= '1; pclk_q2 <= 1'b1;
    end else begin
      pclk_q2 <= pad_clk2;
      if (latch2) rsp2 <= word2;
      else if (pad_clk2 && !pclk_q2) rsp2 <= {rsp2[6:0], 1'b1};
    end
  end
  assign data2 = rsp2[7];

  // One transaction on dut: cycles from accepting edge to valid, clk rises, latch-high cycles
  task automatic do_txn(input logic [15:0] w, output int lat, output int rises,
                        output int lhigh, output logic [15:0] ov);
    logic prev;
    logic done;
    word1 = w;
    @(negedge system_clock); start = 1'b1;
    @(posedge system_clock); #1; start = 1'b0;
    lat = 0; rises = 0; lhigh = 0; prev = 1'b1; done = 1'b0; ov = 'x;
    while (!done && lat < 1000) begin
      @(posedge system_clock); #1;
      lat++;
      if (latch) lhigh++;
      if (pad_clk && !prev) rises++;
      prev = pad_clk;
      if (valid) begin done = 1'b1; ov = o; end
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (latch !== 1'b0) begin bad++; $display("FAIL reset_latch got=%b exp=0", latch); end
    total++; if (pad_clk !== 1'b1) begin bad++; $display("FAIL reset_clk got=%b exp=1", pad_clk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid); end
    total++; if (o !== 16'hFFFF) begin bad++; $display("FAIL reset_o got=%h exp=ffff", o); end
    total++; if (o2 !== 8'hFF) begin bad++; $display("FAIL reset_o2 got=%h exp=ff", o2); end
    @(negedge system_clock); reset_n = 1'b1;
    repeat (3) @(posedge system_clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int lat, rises, lhigh;
    logic [15:0] ov;
    do_txn(16'hA5C3, lat, rises, lhigh, ov);
    total++; if (lat !== 269) begin bad++; $display("FAIL a5c3_latency got=%0d exp=269", lat); end
    total++; if (rises !== 16) begin bad++; $display("FAIL a5c3_rises got=%0d exp=16", rises); end
    total++; if (lhigh !== 12) begin bad++; $display("FAIL a5c3_latch got=%0d exp=12", lhigh); end
    total++; if (ov !== 16'hA5C3) begin bad++; $display("FAIL a5c3_o got=%h exp=a5c3", ov); end
    @(posedge system_clock); #1;
    total++; if (valid !== 1'b0) begin bad++; $display("FAIL a5c3_valid_width got=%b exp=0", valid); end
    total++; if (o !== 16'hA5C3) begin bad++; $display("FAIL a5c3_o_hold got=%h exp=a5c3", o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL a5c3_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_tied();
    int lat, rises, lhigh;
    logic [15:0] ov;
    do_txn(16'h0000, lat, rises, lhigh, ov);
    total++; if (ov !== 16'h0000) begin bad++; $display("FAIL zeros_o got=%h exp=0000", ov); end
    total++; if (lhigh !== 12) begin bad++; $display("FAIL zeros_latch got=%0d exp=12", lhigh); end
    do_txn(16'hFFFF, lat, rises, lhigh, ov);
    total++; if (ov !== 16'hFFFF) begin bad++; $display("FAIL ones_o got=%h exp=ffff", ov); end
    total++; if (lhigh !== 12) begin bad++; $display("FAIL ones_latch got=%0d exp=12", lhigh); end
    total++; if (lat !== 269) begin bad++; $display("FAIL ones_latency got=%0d exp=269", lat); end
  endtask

  task automatic test_start_ignored();
    int nvalid, rises;
    logic prev;
    logic [15:0] ov;
    word1 = 16'h0F0F;
    @(negedge system_clock); start = 1'b1;
    @(posedge system_clock); #1; start = 1'b0;
    nvalid = 0; rises = 0; prev = 1'b1; ov = 'x;
    for (int c = 1; c <= 400; c++) begin
      @(posedge system_clock); #1;
      if (c == 95) start = 1'b1;
      if (c == 96) start = 1'b0;
      if (pad_clk && !prev) rises++;
      prev = pad_clk;
      if (valid) begin nvalid++; ov = o; end
    end
    total++; if (nvalid !== 1) begin bad++; $display("FAIL ignore_valid_count got=%0d exp=1", nvalid); end
    total++; if (rises !== 16) begin bad++; $display("FAIL ignore_rises got=%0d exp=16", rises); end
    total++; if (ov !== 16'h0F0F) begin bad++; $display("FAIL ignore_o got=%h exp=0f0f", ov); end
  endtask

  task automatic test_back_to_back();
    int t, idx;
    int times[3];
    logic [15:0] os[3];
    logic [15:0] exp_o[3];
    exp_o[0] = 16'h1234; exp_o[1] = 16'hFFFE; exp_o[2] = 16'h8001;
    for (int i = 0; i < 3; i++) begin times[i] = -1; os[i] = 'x; end
    word1 = exp_o[0];
    @(negedge system_clock); start = 1'b1;
    @(posedge system_clock); #1;
    t = 0; idx = 0;
    while (idx < 3 && t < 1000) begin
      @(posedge system_clock); #1;
      t++;
      if (valid) begin
        times[idx] = t; os[idx] = o; idx++;
        if (idx < 3) word1 = exp_o[idx];
        else start = 1'b0;
      end
    end
    start = 1'b0;
    total++; if (times[0] !== 269) begin bad++; $display("FAIL b2b_first got=%0d exp=269", times[0]); end
    total++; if (times[1] - times[0] !== 270) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=270", times[1] - times[0]); end
    total++; if (times[2] - times[1] !== 270) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=270", times[2] - times[1]); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (os[i] !== exp_o[i]) begin bad++; $display("FAIL b2b_o%0d got=%h exp=%h", i, os[i], exp_o[i]); end
    end
    repeat (5) @(posedge system_clock);
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL b2b_stop_busy got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid();
    int nvalid, lat, rises, lhigh;
    logic [15:0] ov;
    word1 = 16'hAAAA;
    @(negedge system_clock); start = 1'b1;
    @(posedge system_clock); #1; start = 1'b0;
    repeat (167) @(posedge system_clock);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before got=%b exp=1", busy); end
    #2; reset_n = 1'b0; #1;
    total++; if (latch !== 1'b0) begin bad++; $display("FAIL mid_latch got=%b exp=0", latch); end
    total++; if (pad_clk !== 1'b1) begin bad++; $display("FAIL mid_clk got=%b exp=1", pad_clk); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy got=%b exp=0", busy); end
    total++; if (o !== 16'hFFFF) begin bad++; $display("FAIL mid_o got=%h exp=ffff", o); end
    @(negedge system_clock); reset_n = 1'b1;
    nvalid = 0;
    for (int c = 0; c < 300; c++) begin
      @(posedge system_clock); #1;
      if (valid) nvalid++;
    end
    total++; if (nvalid !== 0) begin bad++; $display("FAIL mid_no_valid got=%0d exp=0", nvalid); end
    total++; if (o !== 16'hFFFF) begin bad++; $display("FAIL mid_o_hold got=%h exp=ffff", o); end
    do_txn(16'h3C96, lat, rises, lhigh, ov);
    total++; if (ov !== 16'h3C96) begin bad++; $display("FAIL mid_next_o got=%h exp=3c96", ov); end
    total++; if (lat !== 269) begin bad++; $display("FAIL mid_next_latency got=%0d exp=269", lat); end
    total++; if (rises !== 16) begin bad++; $display("FAIL mid_next_rises got=%0d exp=16", rises); end
  endtask

  task automatic test_small();
    int lat, rises, lhigh;
    logic prev, done;
    logic [7:0] ov;
    word2 = 8'h5A;
    @(negedge system_clock); start2 = 1'b1;
    @(posedge system_clock); #1; start2 = 1'b0;
    lat = 0; rises = 0; lhigh = 0; prev = 1'b1; done = 1'b0; ov = 'x;
    while (!done && lat < 500) begin
      @(posedge system_clock); #1;
      lat++;
      if (latch2) lhigh++;
      if (pad_clk2 && !prev) rises++;
      prev = pad_clk2;
      if (valid2) begin done = 1'b1; ov = o2; end
    end
    total++; if (lat !== 130) begin bad++; $display("FAIL small_latency got=%0d exp=130", lat); end
    total++; if (ov !== 8'h5A) begin bad++; $display("FAIL small_o got=%h exp=5a", ov); end
    total++; if (rises !== 8) begin bad++; $display("FAIL small_rises got=%0d exp=8", rises); end
    total++; if (lhigh !== 1) begin bad++; $display("FAIL small_latch got=%0d exp=1", lhigh); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tied();
    test_start_ignored();
    test_back_to_back();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pad_reader.md
PAD_READER -- requirements
Module: pad_reader

Interface
REQ-001 Parameter BITS, default 16, number of serial bits read per transaction, MSB first.
REQ-002 Parameter HALF_CYCLES, default 8, system_clock cycles per clk half-period; legal range 8 to 65535.
REQ-003 Parameter LATCH_CYCLES, default 12, system_clock cycles latch is held high; legal range 1 to 65535.
REQ-004 system_clock  input  1  sole clock; all state on its rising edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  request one transaction; sampled only in IDLE.
REQ-007 latch  output  1  parallel-load strobe to the serial responder, active high.
REQ-008 clk  output  1  shift clock to the responder; idles high, responder shifts on its rising edge.
REQ-009 data  input  1  serial data from the responder; asynchronous to system_clock.
REQ-010 o  output  BITS  last completed word; o[BITS-1] is the first bit received.
REQ-011 valid  output  1  one-cycle pulse when o is updated.
REQ-012 busy  output  1  high in every state except IDLE.

Function
REQ-013 data shall pass through a two-flop synchronizer before use; all samples use the synchronized value.
REQ-014 States: IDLE, LATCH, LOW, HIGH, DONE; latch, clk and busy are registered outputs decoded from state.
REQ-015 IDLE: latch=0, clk=1, busy=0; start=1 at edge N moves to LATCH, with latch=1 and busy=1 from N+1.
REQ-016 LATCH: latch=1, clk=1 for exactly LATCH_CYCLES cycles, then LOW with bit counter cleared.
REQ-017 LOW: latch=0, clk=0 for exactly HALF_CYCLES cycles; on the last LOW cycle the synchronized data bit shifts into the LSB of an internal BITS-wide register, and the bit counter increments.
REQ-018 HIGH: clk=1 for exactly HALF_CYCLES cycles; then DONE if the bit counter equals BITS, else LOW.
REQ-019 One transaction shall produce exactly BITS clk rising edges and BITS samples; each sample precedes its rising edge.
REQ-020 DONE lasts one cycle: o is loaded from the shift register and valid=1; the next state is IDLE.
REQ-021 Latency: valid is high exactly LATCH_CYCLES + 2*BITS*HALF_CYCLES + 1 cycles after the edge that accepted start.
REQ-022 start outside IDLE is ignored and not queued; start held high continuously restarts on the cycle after DONE returns to IDLE.
REQ-023 o holds its value between DONE cycles; valid is low in every other cycle.
REQ-024 The half-period/latch cycle counter shall be 16 bits and the bit counter shall be $clog2(BITS+1) bits wide; neither shall wrap within a transaction.

Reset
REQ-025 reset_n=0 forces, asynchronously: state=IDLE, latch=0, clk=1, valid=0, busy=0, o=all ones, shift register=all ones, counters=0, synchronizer flops=1.
REQ-026 Reset asserted mid-transaction aborts it with no valid pulse; o keeps its reset value of all ones until the next completed transaction.
REQ-027 After reset_n rises, the first start accepted in IDLE begins a full transaction from LATCH.

Verification
REQ-028 Default parameters, responder model loaded with 16'hA5C3, single start pulse -> 16 clk rising edges, valid at cycle 269 after acceptance, o=16'hA5C3.
REQ-029 Responder with data tied 0 -> o=16'h0000; with data tied 1 -> o=16'hFFFF; latch high for exactly 12 cycles each time.
REQ-030 start pulsed again during LOW of bit 5 -> ignored; exactly one valid pulse and 16 clk rising edges.
REQ-031 start held high for 3 transactions with words 16'h1234, 16'hFFFE, 16'h8001 -> three valid pulses spaced 270 cycles apart with matching o values.
REQ-032 reset_n pulsed low during HIGH of bit 9 -> latch=0, clk=1, busy=0 immediately, no valid pulse, o=16'hFFFF; the next start completes normally.
REQ-033 BITS=8, HALF_CYCLES=8, LATCH_CYCLES=1, word 8'h5A -> valid 130 cycles after acceptance, o=8'h5A.
